// File: rtl/mercury2_adc_spi_responder_if.sv
// SPI pin bundle between an MCP3008-style ADC master and the Mercury2 ADC responder.
interface mercury2_adc_spi_responder_if;
  logic adc_cs;
  logic adc_clk;
  logic adc_mosi;
  logic adc_miso;

  modport master (output adc_cs, output adc_clk, output adc_mosi, input adc_miso);
  modport slave  (input adc_cs, input adc_clk, input adc_mosi, output adc_miso);
endinterface

// File: rtl/mercury2_adc_spi_responder.sv
// Device-side model of the Mercury2 8-channel 10-bit SPI ADC (MCP3008 protocol).
// All SPI pins are oversampled by the system clock through flip-flop synchronizers.
// Optional build macro: MERC2_ADC_RESP_PATTERN_EN returns {channel, conversion count}
// instead of the sample port, for self-checking loopback.
module mercury2_adc_spi_responder #(
  parameter int DATA_BITS   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mercury2_adc_spi_responder_if.slave spi,
  input  logic [DATA_BITS-1:0]  sample,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_channel,
  output logic                  cmd_diffn,
  output logic [COUNT_W-1:0]    conv_count
);

  localparam int BCNT_W = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_CMD, S_NULLB, S_SHIFT, S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, clk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, clk_prev_q;
  logic [SYNC_STAGES:0]   settle_q;

  state_t                 state_q, state_d;
  logic                   miso_q, miso_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [2:0]             cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [2:0]             ch_q, ch_d;
  logic                   diffn_q, diffn_d;
  logic [COUNT_W-1:0]     count_q, count_d;

  logic                   cs_s, clk_s, mosi_s;
  logic                   cs_fall, clk_rise, clk_fall;
  logic [DATA_BITS-1:0]   latch_val;

  // Synchronize the SPI pins; settle_q marks which stages hold real pin samples after reset,
  // so a cs already low at reset release is never mistaken for a fresh falling edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cs_sync_q   <= '1;
      clk_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      clk_prev_q  <= 1'b0;
      settle_q    <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.adc_cs};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi.adc_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.adc_mosi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = settle_q[SYNC_STAGES] & cs_prev_q & ~cs_s;
  assign clk_rise = ~clk_prev_q & clk_s;
  assign clk_fall = clk_prev_q & ~clk_s;

`ifdef MERC2_ADC_RESP_PATTERN_EN
  logic unused_sample;
  assign unused_sample = ^sample;
  assign latch_val     = {ch_q, count_q[DATA_BITS-4:0]};
`else
  assign latch_val     = sample;
`endif

  // Protocol state and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      miso_q      <= 1'b0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      ch_q        <= '0;
      diffn_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      miso_q      <= miso_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      ch_q        <= ch_d;
      diffn_q     <= diffn_d;
      count_q     <= count_d;
    end
  end

  // Next-state decode: cs high overrides everything, including a clk edge in the same cycle.
  always_comb begin
    state_d     = state_q;
    miso_d      = miso_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    ch_d        = ch_q;
    diffn_d     = diffn_q;
    count_d     = count_q;
    if (cs_s) begin
      state_d  = S_IDLE;
      miso_d   = 1'b0;
      bitcnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_START;
            miso_d  = 1'b0;
          end
        end
        S_START: begin
          if (clk_rise && mosi_s) begin
            state_d  = S_CMD;
            bitcnt_d = '0;
          end
        end
        S_CMD: begin
          if (clk_rise) begin
            cmd_d    = {cmd_q[1:0], mosi_s};
            bitcnt_d = bitcnt_q + BCNT_W'(1);
            if (bitcnt_q == BCNT_W'(3)) begin
              cmd_valid_d = 1'b1;
              diffn_d     = cmd_q[2];
              ch_d        = {cmd_q[1:0], mosi_s};
              state_d     = S_NULLB;
            end
          end
        end
        S_NULLB: begin
          if (clk_fall) begin
            shreg_d  = latch_val;
            miso_d   = 1'b0;
            bitcnt_d = '0;
            state_d  = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (clk_fall) begin
            miso_d   = shreg_q[DATA_BITS-1];
            shreg_d  = {shreg_q[DATA_BITS-2:0], 1'b0};
            bitcnt_d = bitcnt_q + BCNT_W'(1);
            if (bitcnt_q == BCNT_W'(DATA_BITS-1)) begin
              count_d = count_q + COUNT_W'(1);
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (clk_fall) miso_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign spi.adc_miso = miso_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_channel  = ch_q;
  assign cmd_diffn    = diffn_q;
  assign conv_count   = count_q;

endmodule

// File: tb/tb_mercury2_adc_spi_responder.sv
// Directed bench for mercury2_adc_spi_responder: acts as an MCP3008 master at a
// half-period of 8 system clocks and checks the returned frames against hand-computed values.
module tb_mercury2_adc_spi_responder;

  localparam int HP = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  sample;
  logic        cmd_valid;
  logic [2:0]  cmd_channel;
  logic        cmd_diffn;
  logic [15:0] conv_count;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;

  logic [15:0] exp_cnt;

  mercury2_adc_spi_responder_if spi_if ();

  mercury2_adc_spi_responder #(.DATA_BITS(10), .SYNC_STAGES(2), .COUNT_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .spi         (spi_if.slave),
    .sample      (sample),
    .cmd_valid   (cmd_valid),
    .cmd_channel (cmd_channel),
    .cmd_diffn   (cmd_diffn),
    .conv_count  (conv_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cmd_valid === 1'b1) vcnt <= vcnt + 1;
  end

  typedef struct {
    int         lead;
    bit         diffn;
    logic [2:0] ch;
    logic [9:0] smp;
    logic [2:0] exp_ch;
    bit         exp_diffn;
    logic [9:0] exp_res;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bit_cycle(input logic v, output logic b);
    spi_if.adc_mosi = v;
    idle(HP);
    b = spi_if.adc_miso;
    spi_if.adc_clk = 1'b1;
    idle(HP);
    spi_if.adc_clk = 1'b0;
  endtask

  // One transfer: leading zeros, start, SGL/DIFF, D2..D0, then nread sampled bits.
  task automatic conv(input int lead, input bit diffn, input logic [2:0] ch,
                      input logic [9:0] smp, input int nread, input bit tog,
                      output logic [10:0] rd, output logic mb);
    logic b;
    sample = smp;
    spi_if.adc_cs = 1'b0;
    idle(HP);
    for (int i = 0; i < lead; i++) bit_cycle(1'b0, b);
    bit_cycle(1'b1, b);
    bit_cycle(diffn, b);
    bit_cycle(ch[2], b);
    bit_cycle(ch[1], b);
    bit_cycle(ch[0], b);
    rd = '0;
    for (int i = 0; i < nread; i++) begin
      bit_cycle(1'b0, b);
      rd = {rd[9:0], b};
      if (tog) sample = 10'($urandom);
    end
    idle(HP);
    mb = spi_if.adc_miso;
    spi_if.adc_cs = 1'b1;
    idle(2 * HP);
  endtask

  task automatic conv_check(input string tag, input int lead, input bit diffn,
                            input logic [2:0] ch, input logic [9:0] smp,
                            input logic [2:0] e_ch, input bit e_diffn,
                            input logic [9:0] e_res, input bit tog);
    logic [10:0] rd;
    logic        mb;
    logic [9:0]  res;
    int          v0;
    res = e_res;
`ifdef MERC2_ADC_RESP_PATTERN_EN
    res = {e_ch, exp_cnt[6:0]};
`endif
    v0 = vcnt;
    conv(lead, diffn, ch, smp, 11, tog, rd, mb);
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_frame"}, 32'(rd), 32'({1'b0, res}));
    chk({tag, "_vld"}, 32'(vcnt - v0), 32'd1);
    chk({tag, "_ch"}, 32'(cmd_channel), 32'(e_ch));
    chk({tag, "_diffn"}, 32'(cmd_diffn), 32'(e_diffn));
    chk({tag, "_count"}, 32'(conv_count), 32'(exp_cnt));
    chk({tag, "_miso_idle"}, 32'(spi_if.adc_miso), 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    logic [10:0] rd;
    logic        mb, b, or_miso;
    int          v0;

    vecs[0] = '{lead: 0, diffn: 1'b1, ch: 3'd3, smp: 10'h2A5, exp_ch: 3'd3, exp_diffn: 1'b1, exp_res: 10'h2A5};
    vecs[1] = '{lead: 2, diffn: 1'b0, ch: 3'd5, smp: 10'h3FF, exp_ch: 3'd5, exp_diffn: 1'b0, exp_res: 10'h3FF};
    vecs[2] = '{lead: 0, diffn: 1'b1, ch: 3'd0, smp: 10'h000, exp_ch: 3'd0, exp_diffn: 1'b1, exp_res: 10'h000};
    vecs[3] = '{lead: 1, diffn: 1'b0, ch: 3'd7, smp: 10'h155, exp_ch: 3'd7, exp_diffn: 1'b0, exp_res: 10'h155};
    vecs[4] = '{lead: 0, diffn: 1'b1, ch: 3'd6, smp: 10'h200, exp_ch: 3'd6, exp_diffn: 1'b1, exp_res: 10'h200};

    // Reset held with SPI pins toggling.
    reset_n = 1'b0;
    sample = 10'h3FF;
    spi_if.adc_cs = 1'b1;
    spi_if.adc_clk = 1'b0;
    spi_if.adc_mosi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spi_if.adc_cs = i[0];
      spi_if.adc_clk = ~spi_if.adc_clk;
      spi_if.adc_mosi = ~i[1];
      @(negedge clock);
      chk("rst_miso", 32'(spi_if.adc_miso), 32'd0);
      chk("rst_vld", 32'(cmd_valid), 32'd0);
      chk("rst_count", 32'(conv_count), 32'd0);
    end
    spi_if.adc_cs = 1'b1;
    spi_if.adc_clk = 1'b0;
    spi_if.adc_mosi = 1'b0;
    reset_n = 1'b1;
    idle(8);
    chk("rst_ch", 32'(cmd_channel), 32'd0);
    chk("rst_diffn", 32'(cmd_diffn), 32'd0);
    exp_cnt = 16'd0;

    // Table of full conversions.
    for (int i = 0; i < 5; i++) begin
      conv_check($sformatf("vec%0d", i), vecs[i].lead, vecs[i].diffn, vecs[i].ch, vecs[i].smp,
                 vecs[i].exp_ch, vecs[i].exp_diffn, vecs[i].exp_res, 1'b0);
    end

    // Abort after 4 result bits; B5 (=1) is on the pin when cs rises.
    v0 = vcnt;
    conv(0, 1'b1, 3'd2, 10'h3E0, 5, 1'b0, rd, mb);
`ifdef MERC2_ADC_RESP_PATTERN_EN
    chk("abort_frame", 32'(rd[4:0]), 32'({1'b0, 3'd2, exp_cnt[6]}));
`else
    chk("abort_frame", 32'(rd[4:0]), 32'h0F);
    chk("abort_b5_before_cs", 32'(mb), 32'd1);
`endif
    chk("abort_vld", 32'(vcnt - v0), 32'd1);
    chk("abort_miso", 32'(spi_if.adc_miso), 32'd0);
    chk("abort_count", 32'(conv_count), 32'(exp_cnt));
    chk("abort_ch", 32'(cmd_channel), 32'd2);
    conv_check("post_abort", 0, 1'b1, 3'd4, 10'h0F0, 3'd4, 1'b1, 10'h0F0, 1'b0);

    // Reset asserted mid-shift, released while cs is still low.
    sample = 10'h3FF;
    spi_if.adc_cs = 1'b0;
    idle(HP);
    bit_cycle(1'b1, b);
    bit_cycle(1'b1, b);
    bit_cycle(1'b1, b);
    bit_cycle(1'b1, b);
    bit_cycle(1'b1, b);
    bit_cycle(1'b0, b);
    bit_cycle(1'b0, b);
    bit_cycle(1'b0, b);
    chk("midrst_pre_b", 32'(b), 32'd1);
    reset_n = 1'b0;
    idle(2);
    chk("midrst_miso", 32'(spi_if.adc_miso), 32'd0);
    chk("midrst_count", 32'(conv_count), 32'd0);
    chk("midrst_ch", 32'(cmd_channel), 32'd0);
    chk("midrst_diffn", 32'(cmd_diffn), 32'd0);
    reset_n = 1'b1;
    v0 = vcnt;
    or_miso = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_cycle(1'b1, b);
      or_miso = or_miso | b;
    end
    chk("postrst_ignored_vld", 32'(vcnt - v0), 32'd0);
    chk("postrst_ignored_miso", 32'(or_miso), 32'd0);
    chk("postrst_ignored_count", 32'(conv_count), 32'd0);
    spi_if.adc_cs = 1'b1;
    spi_if.adc_mosi = 1'b0;
    idle(2 * HP);
    exp_cnt = 16'd0;
    conv_check("after_rst", 0, 1'b0, 3'd1, 10'h12C, 3'd1, 1'b0, 10'h12C, 1'b0);

    // Counter wrap from all ones.
    force dut.count_q = 16'hFFFF;
    idle(2);
    release dut.count_q;
    idle(1);
    chk("wrap_preload", 32'(conv_count), 32'hFFFF);
    exp_cnt = 16'hFFFF;
    conv_check("wrap", 0, 1'b1, 3'd3, 10'h2A5, 3'd3, 1'b1, 10'h2A5, 1'b0);
    chk("wrap_zero", 32'(conv_count), 32'd0);

`ifdef MERC2_ADC_RESP_PATTERN_EN
    // Pattern mode: channel 6 at count 5 returns 10'h305 regardless of the sample port.
    force dut.count_q = 16'd5;
    idle(2);
    release dut.count_q;
    idle(1);
    exp_cnt = 16'd5;
    conv_check("pattern", 0, 1'b1, 3'd6, 10'h0AA, 3'd6, 1'b1, 10'h305, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
